// File: rtl/mips_run_pkg.sv
`default_nettype none
// ============================================================
// mips_run_pkg : shared state encoding and load-stream constants
// Rev 1.0
// ============================================================
package mips_run_pkg;
    localparam int   LD_AW    = 16;
    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_RUN      = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_CAP = 3'd4,
        ST_DUMP_OUT = 3'd5,
        ST_DONE     = 3'd6,
        ST_TMO      = 3'd7
    } run_state_e;
endpackage
`default_nettype wire

// File: rtl/mips_dump_engine.sv
`default_nettype none
// ============================================================
// mips_dump_engine : read/capture/output walk over a dmem window
// Rev 1.0
// ============================================================
module mips_dump_engine
    import mips_run_pkg::*;
#(
    parameter int DMEM_AW = 10
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic               load,
    input  logic               start,
    input  logic               abort,
    input  logic [DMEM_AW-1:0] base,
    input  logic [DMEM_AW:0]   len,
    input  logic               dump_ready,
    input  logic [31:0]        dmem_rdata,
    output logic               rd_en,
    output logic [DMEM_AW-1:0] rd_addr,
    output logic               len_zero,
    output logic               finished,
    output logic               dump_valid,
    output logic [31:0]        dump_data
);
    run_state_e         phase_q, phase_d;
    logic [DMEM_AW-1:0] ptr_q, ptr_d;
    logic [DMEM_AW:0]   rem_q, rem_d;
    logic [31:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               re_q, re_d;

    always_comb begin
        phase_d  = phase_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        re_d     = 1'b0;
        finished = 1'b0;
        if (abort) begin
            phase_d = ST_IDLE;
        end else if (load) begin
            ptr_d   = base;
            rem_d   = len;
            phase_d = ST_IDLE;
        end else begin
            case (phase_q)
                ST_IDLE: if (start) begin
                    phase_d = ST_DUMP_RD;
                    re_d    = 1'b1;
                end
                ST_DUMP_RD:  phase_d = ST_DUMP_CAP;
                ST_DUMP_CAP: begin
                    data_d  = dmem_rdata;
                    valid_d = 1'b1;
                    phase_d = ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    valid_d = 1'b1;
                    if (dump_ready) begin
                        valid_d = 1'b0;
                        ptr_d   = ptr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        if (rem_q == (DMEM_AW+1)'(1)) begin
                            finished = 1'b1;
                            phase_d  = ST_IDLE;
                        end else begin
                            re_d    = 1'b1;
                            phase_d = ST_DUMP_RD;
                        end
                    end
                end
                default: phase_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            re_q    <= re_d;
        end
    end

    assign rd_en      = re_q;
    assign rd_addr    = ptr_q;
    assign len_zero   = (rem_q == '0);
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
endmodule
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================
// mips_run_ctrl : load, init, run, time and dump the MIPS32 core
// Option macro: MIPS_RUN_CTRL_DUMP_EN (data-memory dump)
// Rev 1.0
// ============================================================
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int IMEM_AW   = 10,
    parameter int DMEM_AW   = 10,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic                 ld_sel,
    input  logic [LD_AW-1:0]     ld_addr,
    input  logic [31:0]          ld_data,
    input  logic                 start,
    input  logic                 clr,
    output logic                 core_hold,
    output logic                 core_init,
    input  logic                 core_halted,
    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_waddr,
    output logic [31:0]          imem_wdata,
    output logic                 dmem_we,
    output logic                 dmem_re,
    output logic [DMEM_AW-1:0]   dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic [DMEM_AW-1:0]   dump_base,
    input  logic [DMEM_AW:0]     dump_len,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [31:0]          dump_data,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [TIMEOUT_W-1:0] cycle_count
);
    run_state_e           state_q, state_d;
    logic [TIMEOUT_W-1:0] count_q, count_d, count_inc;
    logic                 hold_q, hold_d, init_q, init_d, busy_q, busy_d;
    logic                 done_q, done_d, tmo_q, tmo_d, rdy_q, rdy_d;
    logic                 iwe_q, iwe_d, dwe_q, dwe_d;
    logic [IMEM_AW-1:0]   iaddr_q, iaddr_d;
    logic [DMEM_AW-1:0]   daddr_q, daddr_d;
    logic [31:0]          idata_q, idata_d, ddata_q, ddata_d;
    logic                 accept;
    logic                 eng_start, eng_rd_en, eng_len_zero, eng_finished;
    logic [DMEM_AW-1:0]   eng_rd_addr;
    logic                 unused_ld;

    assign count_inc = count_q + 1'b1;
    assign unused_ld = ^ld_addr;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        eng_start = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_INIT;
                count_d = '0;
            end
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                count_d = count_inc;
                // Halt is checked first so it wins over the count limit.
                if (core_halted) begin
                    if (eng_len_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_DUMP_RD;
                        eng_start = 1'b1;
                    end
                end else if (&count_inc) begin
                    state_d = ST_TMO;
                end
            end
            // The top parks here while the engine walks RD/CAP/OUT.
            ST_DUMP_RD: if (eng_finished) state_d = ST_DONE;
            ST_DONE, ST_TMO: ;
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            eng_start = 1'b0;
        end

        hold_d = (state_d != ST_RUN);
        init_d = (state_d == ST_INIT);
        busy_d = (state_d == ST_INIT) || (state_d == ST_RUN) || (state_d == ST_DUMP_RD)
              || (state_d == ST_DUMP_CAP) || (state_d == ST_DUMP_OUT);
        done_d = (state_d == ST_DONE);
        tmo_d  = (state_d == ST_TMO);
        rdy_d  = (state_d == ST_IDLE);

        accept  = ld_valid && rdy_q && !clr;
        iwe_d   = accept && (ld_sel == SEL_IMEM);
        dwe_d   = accept && (ld_sel == SEL_DMEM);
        iaddr_d = iwe_d ? ld_addr[IMEM_AW-1:0] : iaddr_q;
        idata_d = iwe_d ? ld_data : idata_q;
        daddr_d = dwe_d ? ld_addr[DMEM_AW-1:0] : daddr_q;
        ddata_d = dwe_d ? ld_data : ddata_q;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hold_q  <= 1'b1;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            rdy_q   <= 1'b1;
            iwe_q   <= 1'b0;
            dwe_q   <= 1'b0;
            iaddr_q <= '0;
            idata_q <= '0;
            daddr_q <= '0;
            ddata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            rdy_q   <= rdy_d;
            iwe_q   <= iwe_d;
            dwe_q   <= dwe_d;
            iaddr_q <= iaddr_d;
            idata_q <= idata_d;
            daddr_q <= daddr_d;
            ddata_q <= ddata_d;
        end
    end

`ifdef MIPS_RUN_CTRL_DUMP_EN
    mips_dump_engine #(.DMEM_AW(DMEM_AW)) u_dump (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .load       (state_q == ST_INIT),
        .start      (eng_start),
        .abort      (clr),
        .base       (dump_base),
        .len        (dump_len),
        .dump_ready (dump_ready),
        .dmem_rdata (dmem_rdata),
        .rd_en      (eng_rd_en),
        .rd_addr    (eng_rd_addr),
        .len_zero   (eng_len_zero),
        .finished   (eng_finished),
        .dump_valid (dump_valid),
        .dump_data  (dump_data)
    );
`else
    logic unused_dump;
    assign unused_dump  = ^{dump_ready, dump_base, dump_len, dmem_rdata, eng_start};
    assign eng_rd_en    = 1'b0;
    assign eng_rd_addr  = '0;
    assign eng_len_zero = 1'b1;
    assign eng_finished = 1'b0;
    assign dump_valid   = 1'b0;
    assign dump_data    = '0;
`endif

    assign ld_ready    = rdy_q;
    assign core_hold   = hold_q;
    assign core_init   = init_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = tmo_q;
    assign cycle_count = count_q;
    assign imem_we     = iwe_q;
    assign imem_waddr  = iaddr_q;
    assign imem_wdata  = idata_q;
    assign dmem_we     = dwe_q;
    assign dmem_wdata  = ddata_q;
    assign dmem_re     = eng_rd_en;
    assign dmem_addr   = eng_rd_en ? eng_rd_addr : daddr_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================
// tb_mips_run_ctrl : directed bench with a behavioural core and dmem
// Rev 1.0
// ============================================================
module tb_mips_run_ctrl;
    logic        clk1 = 1'b0;
    logic        rst_n, ld_valid, ld_sel, start, clr, dump_ready;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic [9:0]  dump_base;
    logic [10:0] dump_len;
    logic        core_halted;
    logic [31:0] dmem_rdata;
    logic        no_halt = 1'b0;

    logic        ld_ready, core_hold, core_init, imem_we, dmem_we, dmem_re;
    logic        dump_valid, busy, done, timeout;
    logic [9:0]  imem_waddr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata, dump_data;
    logic [15:0] cycle_count;

    logic        t4_ld_ready, t4_core_hold, t4_core_init, t4_imem_we, t4_dmem_we, t4_dmem_re;
    logic        t4_dump_valid, t4_busy, t4_done, t4_timeout;
    logic [9:0]  t4_imem_waddr, t4_dmem_addr;
    logic [31:0] t4_imem_wdata, t4_dmem_wdata, t4_dump_data;
    logic [3:0]  t4_cycle_count;

    int total = 0;
    int bad   = 0;
    int halt_at = 0;
    int core_cnt;
    logic [31:0] mem [1024];

    always #5 clk1 = ~clk1;

    mips_run_ctrl dut (
        .clk1(clk1), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .clr(clr), .core_hold(core_hold),
        .core_init(core_init), .core_halted(core_halted), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dump_base(dump_base), .dump_len(dump_len),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .busy(busy),
        .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    mips_run_ctrl #(.TIMEOUT_W(4)) dut4 (
        .clk1(clk1), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(t4_ld_ready), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .clr(clr), .core_hold(t4_core_hold),
        .core_init(t4_core_init), .core_halted(no_halt), .imem_we(t4_imem_we),
        .imem_waddr(t4_imem_waddr), .imem_wdata(t4_imem_wdata), .dmem_we(t4_dmem_we),
        .dmem_re(t4_dmem_re), .dmem_addr(t4_dmem_addr), .dmem_wdata(t4_dmem_wdata),
        .dmem_rdata(dmem_rdata), .dump_base(dump_base), .dump_len(dump_len),
        .dump_valid(t4_dump_valid), .dump_ready(dump_ready), .dump_data(t4_dump_data),
        .busy(t4_busy), .done(t4_done), .timeout(t4_timeout), .cycle_count(t4_cycle_count)
    );

    // Core raises HALTED so that the FSM sees it in run cycle halt_at.
    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt    <= 0;
            core_halted <= 1'b0;
        end else if (core_init) begin
            core_cnt    <= 0;
            core_halted <= 1'b0;
        end else if (!core_hold) begin
            core_cnt <= core_cnt + 1;
            if (halt_at > 1 && core_cnt + 1 == halt_at - 1) core_halted <= 1'b1;
        end
    end

    always @(posedge clk1) begin
        if (dmem_we) mem[dmem_addr] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= mem[dmem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic run_wait(output int n, output int n4, output int ni);
        n = 0; n4 = 0; ni = 0;
        for (int k = 0; k < 300 && !core_hold; k++) begin
            n++;
            if (!t4_core_hold) n4++;
            if (core_init) ni++;
            tick();
        end
        chk("run_end", core_hold, 1'b1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    logic [31:0] prog [8];
    logic [15:0] dl_addr [4];
    logic [31:0] dl_data [4];
    logic [9:0]  dl_exp  [4];
    int n, n4, ni;

    initial begin
        prog    = '{32'h2001000a, 32'h20020014, 32'h00221820, 32'h0c000000,
                    32'hac030078, 32'h8c040078, 32'h00000000, 32'hfc000000};
        dl_addr = '{16'd120, 16'd121, 16'hffff, 16'd0};
        dl_data = '{32'd85, 32'd130, 32'h11, 32'h22};
        dl_exp  = '{10'd120, 10'd121, 10'd1023, 10'd0};
        ld_valid = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; start = 0; clr = 0;
        dump_base = 0; dump_len = 0; dump_ready = 0;
        rst_n = 1'b0;
        #12;
        chk("rst_flags", {core_hold, ld_ready, core_init, imem_we, dmem_we, dmem_re,
                          dump_valid, busy, done, timeout}, 10'b1100000000);
        chk("rst_vals", {cycle_count, dmem_addr, imem_waddr, dump_data}, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            ld_valid = 1; ld_sel = 0; ld_addr = 16'(i); ld_data = prog[i];
            tick();
            chk("imem_strobe", {imem_we, dmem_we}, 2'b10);
            chk("imem_waddr", imem_waddr, 64'(i));
            chk("imem_wdata", imem_wdata, prog[i]);
        end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_sel = 1; ld_addr = dl_addr[i]; ld_data = dl_data[i];
            tick();
            chk("dmem_strobe", {imem_we, dmem_we}, 2'b01);
            chk("dmem_addr", dmem_addr, dl_exp[i]);
            chk("dmem_wdata", dmem_wdata, dl_data[i]);
        end
        ld_valid = 0;
        tick();
        chk("strobe_drop", {imem_we, dmem_we}, 2'b00);

        // Run 1: halt after 20 run cycles; TIMEOUT_W=4 copy times out at 15.
        dump_base = 10'd120; dump_len = 11'd2; halt_at = 20; dump_ready = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init", {core_init, core_hold, busy, ld_ready}, 4'b1110);
        ld_valid = 1; ld_sel = 0; ld_addr = 16'd3; ld_data = 32'hdeadbeef;
        tick();
        ld_valid = 0;
        chk("run_entry", {core_init, core_hold, busy, imem_we}, 4'b0010);
        run_wait(n, n4, ni);
        chk("hold_low", n, 20);
        chk("cycles", cycle_count, 20);
        chk("init_pulses", ni, 0);
        chk("t4_low", n4, 15);
        chk("t4_flags", {t4_timeout, t4_core_hold, t4_done, t4_busy}, 4'b1100);
        chk("t4_count", t4_cycle_count, 15);
`ifdef MIPS_RUN_CTRL_DUMP_EN
        chk("dump_rd", {dmem_re, busy, done, dump_valid}, 4'b1100);
        chk("rd_addr0", dmem_addr, 120);
        tick();
        chk("dump_cap", {dmem_re, dump_valid}, 2'b00);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("stall_word", {dump_valid, dump_data}, {1'b1, 32'd85});
            tick();
        end
        dump_ready = 1;
        tick();
        chk("rd2", {dmem_re, dump_valid}, 2'b10);
        chk("rd_addr1", dmem_addr, 121);
        tick();
        tick();
        chk("word2", {dump_valid, dump_data}, {1'b1, 32'd130});
        tick();
        dump_ready = 0;
        chk("done_dump", {done, busy, dump_valid, core_hold}, 4'b1001);
`else
        chk("done_direct", {done, busy, dump_valid, core_hold, dmem_re}, 5'b10010);
        chk("dump_tied", dump_data, 0);
`endif
        tick();
        chk("done_hold", {done, core_hold, cycle_count}, {2'b11, 16'd20});
        clr = 1;
        tick();
        clr = 0;
        chk("clr_idle", {ld_ready, core_hold, done, timeout, busy}, 5'b11000);
        chk("clr_count", cycle_count, 0);
        chk("t4_clr", {t4_timeout, t4_ld_ready}, 2'b01);

        // Run 2: empty dump window goes straight to DONE.
        dump_len = 0; halt_at = 4;
        do_start();
        run_wait(n, n4, ni);
        chk("len0_low", n, 4);
        chk("len0_done", {done, dmem_re, busy}, 3'b100);
        tick();
        chk("len0_nore", {dmem_re, dump_valid, done}, 3'b001);
        clr = 1;
        tick();
        clr = 0;

`ifdef MIPS_RUN_CTRL_DUMP_EN
        // Run 3: pointer wrap, then clr while a word is offered.
        dump_base = 10'd1023; dump_len = 11'd2; halt_at = 3; dump_ready = 1;
        do_start();
        run_wait(n, n4, ni);
        chk("wrap_low", n, 3);
        chk("wrap_rd0", {dmem_re, dmem_addr}, {1'b1, 10'd1023});
        tick();
        tick();
        chk("wrap_w0", {dump_valid, dump_data}, {1'b1, 32'h11});
        tick();
        chk("wrap_rd1", {dmem_re, dmem_addr}, {1'b1, 10'd0});
        dump_ready = 0;
        tick();
        tick();
        chk("wrap_w1", {dump_valid, dump_data}, {1'b1, 32'h22});
        clr = 1;
        tick();
        clr = 0;
        chk("clr_out", {dump_valid, ld_ready, core_hold, busy, done}, 5'b01100);
`endif

        // Run 4: asynchronous reset in the middle of a run.
        halt_at = 0;
        do_start();
        tick();
        tick();
        chk("mid_run", {core_hold, busy, cycle_count}, {2'b01, 16'd2});
        rst_n = 1'b0;
        #2;
        chk("async_rst", {core_hold, ld_ready, busy, core_init, done, timeout}, 6'b110000);
        chk("async_cnt", cycle_count, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst", {ld_ready, core_hold, busy}, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
